// File: rtl/cursor_blink_seq_pkg.sv
// Shared types and defaults for the cursor blink sequencer.
// Imported by the interface, the edge detector and the top.
package cursor_blink_seq_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_COLOR_W = 3;
  localparam logic [2:0] DEF_CURSOR_COLOR = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WR_W,
    S_ARM,
    S_WAIT,
    S_WR_R,
    S_ARM_B,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/cursor_blink_seq_if.sv
// Framebuffer, timer and control bundle of the blink sequencer.
// master is the sequencer side, slave is the environment side.
interface cursor_blink_seq_if
  import cursor_blink_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COLOR_W = DEF_COLOR_W
);

  logic               en;
  logic [ADDR_W-1:0]  cursor_addr;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COLOR_W-1:0] rd_data;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_gnt;
  logic               tmr_init;
  logic               tmr_done;
  logic               phase_white;
  logic               busy;

  modport master (
    input  en, cursor_addr, rd_data,
    input  wr_gnt, tmr_done,
    output rd_en, rd_addr,
    output wr_req, wr_addr, wr_data,
    output tmr_init, phase_white, busy
  );

  modport slave (
    output en, cursor_addr, rd_data,
    output wr_gnt, tmr_done,
    input  rd_en, rd_addr,
    input  wr_req, wr_addr, wr_data,
    input  tmr_init, phase_white, busy
  );

endinterface

// File: rtl/cursor_blink_seq_edge_det.sv
// Rise/fall detector on a single registered copy of a level.
// Reusable by any consumer of the blank-interval timer.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  // one-cycle history of the input level
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/cursor_blink_seq.sv
// Blinks the paint cursor: save pixel, paint it white, restore it,
// each phase paced by one launch of the blank-interval timer.
module cursor_blink_seq
  import cursor_blink_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = DEF_CURSOR_COLOR
) (
  input logic clk,
  input logic rst,
  cursor_blink_seq_if.master io
);

  state_e             state_q;
  logic [ADDR_W-1:0]  sav_addr_q;
  logic [COLOR_W-1:0] sav_col_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COLOR_W-1:0] wr_data_q;
  logic               rd_en_q;
  logic               wr_req_q;
  logic               tmr_init_q;
  logic               tmr_busy_q;
  logic               pw_q;
  logic               busy_q;
  logic               done_rise;
  logic               done_fall;
  logic               moved;

  edge_det u_done_edge (
    .clk   (clk),
    .rst   (rst),
    .d_i   (io.tmr_done),
    .rise_o(done_rise),
    .fall_o(done_fall)
  );

  assign moved = io.cursor_addr != sav_addr_q;

  // main sequencer; every output is a register set on the transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sav_addr_q <= '0;
      sav_col_q  <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      wr_req_q   <= 1'b0;
      tmr_init_q <= 1'b0;
      tmr_busy_q <= 1'b0;
      pw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      tmr_init_q <= 1'b0;
      // the timer is idle again once its done window has closed
      if (done_fall) tmr_busy_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (io.en) begin
            state_q    <= S_READ;
            rd_en_q    <= 1'b1;
            rd_addr_q  <= io.cursor_addr;
            sav_addr_q <= io.cursor_addr;
            busy_q     <= 1'b1;
          end
        end
        S_READ: begin
          state_q <= io.en ? S_LATCH : S_DRAIN;
        end
        S_LATCH: begin
          sav_col_q <= io.rd_data;
          if (io.en) begin
            state_q   <= S_WR_W;
            wr_req_q  <= 1'b1;
            wr_addr_q <= sav_addr_q;
            wr_data_q <= CURSOR_COLOR;
          end else begin
            state_q <= S_DRAIN;
          end
        end
        S_WR_W: begin
          if (io.wr_gnt) begin
            wr_req_q <= 1'b0;
            pw_q     <= 1'b1;
            state_q  <= S_ARM;
          end
        end
        S_ARM, S_ARM_B: begin
          if (!io.en) begin
            if (pw_q) begin
              state_q   <= S_WR_R;
              wr_req_q  <= 1'b1;
              wr_addr_q <= sav_addr_q;
              wr_data_q <= sav_col_q;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (!tmr_busy_q) begin
            tmr_init_q <= 1'b1;
            tmr_busy_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!io.en || moved || done_rise) begin
            if (pw_q) begin
              state_q   <= S_WR_R;
              wr_req_q  <= 1'b1;
              wr_addr_q <= sav_addr_q;
              wr_data_q <= sav_col_q;
            end else if (!io.en) begin
              state_q <= S_DRAIN;
            end else begin
              state_q    <= S_READ;
              rd_en_q    <= 1'b1;
              rd_addr_q  <= io.cursor_addr;
              sav_addr_q <= io.cursor_addr;
            end
          end
        end
        S_WR_R: begin
          if (io.wr_gnt) begin
            wr_req_q <= 1'b0;
            pw_q     <= 1'b0;
            if (!io.en) begin
              state_q <= S_DRAIN;
            end else if (moved) begin
              state_q    <= S_READ;
              rd_en_q    <= 1'b1;
              rd_addr_q  <= io.cursor_addr;
              sav_addr_q <= io.cursor_addr;
            end else begin
              state_q <= S_ARM_B;
            end
          end
        end
        S_DRAIN: begin
          if (!tmr_busy_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign io.rd_en       = rd_en_q;
  assign io.rd_addr     = rd_addr_q;
  assign io.wr_req      = wr_req_q;
  assign io.wr_addr     = wr_addr_q;
  assign io.wr_data     = wr_data_q;
  assign io.tmr_init    = tmr_init_q;
  assign io.phase_white = pw_q;
  assign io.busy        = busy_q;

endmodule
